// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite types and widths for the register-bank responder and its helpers.
// Contents:
//   AHB_ADDR_W / AHB_DATA_W / AHB_SIZE_W / AHB_BURST_W / AHB_TYPE_W : bus field widths
//   htrans_e, hresp_e, hsize_e : encodings of the AHB control fields
//   slv_state_e                : data-phase state of the responder
//   merge_lanes()              : overlay the strobed byte lanes of a new word onto an old one
package ahb_pkg;

   localparam int AHB_ADDR_W  = 32;
   localparam int AHB_DATA_W  = 32;
   localparam int AHB_SIZE_W  = 3;
   localparam int AHB_BURST_W = 3;
   localparam int AHB_TYPE_W  = 2;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'd0,
      HRESP_ERROR = 2'd1
   } hresp_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DATA = 3'd1,
      ST_WAIT = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slv_state_e;

   // Lane-wise merge used both for the bank write and for forwarding a
   // just-completed write into a read of the same word.
   function automatic logic [AHB_DATA_W-1:0] merge_lanes(
      input logic [AHB_DATA_W-1:0] old_word,
      input logic [AHB_DATA_W-1:0] new_word,
      input logic [3:0]            strobe
   );
      logic [AHB_DATA_W-1:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = strobe[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ahb_slv_bytemask.sv
// ahb_slv_bytemask
// Decodes transfer size and the low address bits into a 4-lane byte strobe and
// flags transfers that are not naturally aligned to their size.
// Ports:
//   hsize      in  3  AHB transfer size (0 byte, 1 half, 2 word; larger gives no strobe)
//   addr_lo    in  2  haddr[1:0]
//   strobe     out 4  byte lanes touched by the transfer
//   misaligned out 1  half on odd address or word not on a 4-byte boundary
module ahb_slv_bytemask
   import ahb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output logic [3:0] strobe,
   output logic       misaligned
);

   // Sizes above a word leave the strobe empty; the top treats them as errors.
   always_comb begin
      strobe     = 4'b0000;
      misaligned = 1'b0;
      case (hsize)
         HSIZE_BYTE: begin
            strobe = 4'b0001 << addr_lo;
         end
         HSIZE_HALF: begin
            strobe     = 4'b0011 << addr_lo;
            misaligned = addr_lo[0];
         end
         HSIZE_WORD: begin
            strobe     = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
            strobe     = 4'b0000;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ahb_slv_regbank.sv
// ahb_slv_regbank
// AHB-Lite responder backed by a flop register bank. Byte-lane writes, registered
// reads with write-to-read forwarding, a two-cycle ERROR response for illegal
// transfers and a saturating count of errored transfers.
// Optional feature macro: AHB_SLV_WAIT_EN adds the cfg_wait port and inserts that
// many wait states (hready low) in front of every good transfer.
// Ports:
//   clk             in   1   bus clock
//   hreset          in   1   asynchronous active-high reset
//   ahb_slv_haddr   in   32  address-phase address
//   ahb_slv_htrans  in   2   IDLE/BUSY/NONSEQ/SEQ
//   ahb_slv_hwrite  in   1   1 write, 0 read
//   ahb_slv_hsize   in   3   byte/half/word, larger is an error
//   ahb_slv_hburst  in   3   accepted but not decoded
//   ahb_slv_hwdata  in   32  data-phase write data
//   slv_ahb_hready  out  1   transfer done
//   slv_ahb_hresp   out  2   OKAY/ERROR
//   slv_ahb_hrdata  out  32  read data
//   err_cnt         out  8   saturating ERROR count
//   cfg_wait        in   4   wait states per transfer (AHB_SLV_WAIT_EN only)
module ahb_slv_regbank
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH = AHB_ADDR_W,
   parameter int DATA_WIDTH = AHB_DATA_W,
   parameter int DEPTH      = 64
) (
   input  logic                   clk,
   input  logic                   hreset,
   input  logic [ADDR_WIDTH-1:0]  ahb_slv_haddr,
   input  logic [AHB_TYPE_W-1:0]  ahb_slv_htrans,
   input  logic                   ahb_slv_hwrite,
   input  logic [AHB_SIZE_W-1:0]  ahb_slv_hsize,
   input  logic [AHB_BURST_W-1:0] ahb_slv_hburst,
   input  logic [DATA_WIDTH-1:0]  ahb_slv_hwdata,
   output logic                   slv_ahb_hready,
   output logic [1:0]             slv_ahb_hresp,
   output logic [DATA_WIDTH-1:0]  slv_ahb_hrdata,
   output logic [7:0]             err_cnt
`ifdef AHB_SLV_WAIT_EN
   ,
   input  logic [3:0]             cfg_wait
`endif
);

   localparam int                    IDX_W      = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * 4);

   slv_state_e            state;
   slv_state_e            next_state;
   hresp_e                resp;
   logic [DATA_WIDTH-1:0] bank [DEPTH];

   logic [IDX_W-1:0]      dp_idx;
   logic [3:0]            dp_strobe;
   logic                  dp_write;
   logic [3:0]            wait_cnt;
   logic [3:0]            wait_sel;

   logic                  addr_valid;
   logic                  accept;
   logic                  size_bad;
   logic                  range_bad;
   logic                  misaligned;
   logic                  addr_bad;
   logic                  good_accept;
   logic                  write_now;
   logic                  fwd_hit;
   logic [3:0]            addr_strobe;
   logic [IDX_W-1:0]      addr_idx;
   logic [DATA_WIDTH-1:0] read_word;
   logic [DATA_WIDTH-1:0] read_val;
   logic                  unused_burst;

`ifdef AHB_SLV_WAIT_EN
   assign wait_sel = cfg_wait;
`else
   assign wait_sel = 4'd0;
`endif

   // Burst type carries no information here since every beat has its own address.
   assign unused_burst = ^ahb_slv_hburst;

   ahb_slv_bytemask u_bytemask (
      .hsize      (ahb_slv_hsize),
      .addr_lo    (ahb_slv_haddr[1:0]),
      .strobe     (addr_strobe),
      .misaligned (misaligned)
   );

   // Address-phase decode: a transfer is taken only while the bus is not stalled,
   // and IDLE/BUSY never open a data phase.
   assign addr_valid  = ahb_slv_htrans[1];
   assign accept      = slv_ahb_hready & addr_valid;
   assign size_bad    = (ahb_slv_hsize > 3'd2);
   assign range_bad   = (ahb_slv_haddr >= ADDR_LIMIT);
   assign addr_bad    = size_bad | range_bad | misaligned;
   assign good_accept = accept & ~addr_bad;
   assign addr_idx    = ahb_slv_haddr[IDX_W+1:2];

   // The write lands at the end of the data-phase cycle; a read accepted on that
   // same edge to the same word must see the merged result, not the stale bank.
   assign write_now = (state == ST_DATA) & dp_write;
   assign fwd_hit   = write_now & (dp_idx == addr_idx);
   assign read_word = bank[addr_idx];
   assign read_val  = fwd_hit ? merge_lanes(read_word, ahb_slv_hwdata, dp_strobe) : read_word;

   // State register.
   always_ff @(posedge clk or posedge hreset) begin
      if (hreset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: ERR1 always moves to ERR2; WAIT drains its counter; every
   // hready-high state can take the next pipelined transfer.
   always_comb begin
      next_state = state;
      case (state)
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = ST_DATA;
            end
         end
         ST_ERR1: begin
            next_state = ST_ERR2;
         end
         default: begin
            if (accept) begin
               if (addr_bad) begin
                  next_state = ST_ERR1;
               end else if (wait_sel != 4'd0) begin
                  next_state = ST_WAIT;
               end else begin
                  next_state = ST_DATA;
               end
            end else begin
               next_state = ST_IDLE;
            end
         end
      endcase
   end

   // Output decode from state alone so hready never depends on the address inputs.
   always_comb begin
      slv_ahb_hready = 1'b1;
      resp           = HRESP_OKAY;
      case (state)
         ST_WAIT: begin
            slv_ahb_hready = 1'b0;
         end
         ST_ERR1: begin
            slv_ahb_hready = 1'b0;
            resp           = HRESP_ERROR;
         end
         ST_ERR2: begin
            resp = HRESP_ERROR;
         end
         default: begin
            slv_ahb_hready = 1'b1;
            resp           = HRESP_OKAY;
         end
      endcase
   end

   assign slv_ahb_hresp = resp;

   // Wait counter loads one less than the requested count so that exactly
   // wait_sel cycles are spent in ST_WAIT.
   always_ff @(posedge clk or posedge hreset) begin
      if (hreset) begin
         wait_cnt <= 4'd0;
      end else if (good_accept && (wait_sel != 4'd0)) begin
         wait_cnt <= wait_sel - 4'd1;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Data-phase control captured only for good transfers; errored transfers
   // never reach ST_DATA so stale values here are harmless.
   always_ff @(posedge clk or posedge hreset) begin
      if (hreset) begin
         dp_idx    <= '0;
         dp_strobe <= 4'b0000;
         dp_write  <= 1'b0;
      end else if (good_accept) begin
         dp_idx    <= addr_idx;
         dp_strobe <= addr_strobe;
         dp_write  <= ahb_slv_hwrite;
      end
   end

   // Register bank: only strobed lanes change when a write completes.
   always_ff @(posedge clk or posedge hreset) begin
      if (hreset) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank[i] <= '0;
         end
      end else if (write_now) begin
         bank[dp_idx] <= merge_lanes(bank[dp_idx], ahb_slv_hwdata, dp_strobe);
      end
   end

   // Read data is captured at the address phase; nothing can write the bank
   // while the read's data phase is stalled, so it stays valid through waits.
   always_ff @(posedge clk or posedge hreset) begin
      if (hreset) begin
         slv_ahb_hrdata <= '0;
      end else if (good_accept && !ahb_slv_hwrite) begin
         slv_ahb_hrdata <= read_val;
      end
   end

   // Errors are counted as the response enters its second (hready high) cycle.
   always_ff @(posedge clk or posedge hreset) begin
      if (hreset) begin
         err_cnt <= 8'd0;
      end else if ((state == ST_ERR1) && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
